// File: rtl/mcu_window_cache.sv
// Multi-channel window cache between the CPU core and backing memory.
// Hits answer in one cycle; misses and advances lock the core and burst-refill a whole window.
module mcu_window_cache #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16,
  parameter int DEPTH = 8,
  parameter int NUM_CH = 2,
  parameter int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter logic [ADDR_W-1:0] MEM_BASE = 32'h1000_0000
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_req,
  input  logic [CH_W-1:0]   i_ch,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_lock_core,
  input  logic              i_adv,
  input  logic [CH_W-1:0]   i_adv_ch,
  input  logic              i_flush,
  output logic [NUM_CH-1:0] o_valid_map,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int OFF_W = $clog2(DEPTH);
  localparam int TAG_W = ADDR_W - OFF_W;
  localparam logic [CH_W:0] CH_LIM = (CH_W+1)'(NUM_CH);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL} state_t;

  logic [DATA_W-1:0] r_mem [NUM_CH][DEPTH];
  logic [TAG_W-1:0]  r_tag [NUM_CH];
  logic [NUM_CH-1:0] r_valid;
  state_t            r_state;
  logic [CH_W-1:0]   r_ch;
  logic [OFF_W-1:0]  r_off;
  logic [OFF_W-1:0]  r_beat;
  logic [TAG_W-1:0]  r_new_tag;
  logic              r_replay;
  logic              r_flush_pend;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_lock;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;

  logic              w_req_ok;
  logic              w_adv_ok;
  logic [TAG_W-1:0]  w_req_tag;
  logic [OFF_W-1:0]  w_req_off;
  logic              w_hit;
  logic [TAG_W-1:0]  w_adv_tag;
  logic [CH_W-1:0]   w_fill_ch;
  logic [TAG_W-1:0]  w_fill_tag;
  logic [ADDR_W-1:0] w_fill_addr;

  // Requests on nonexistent channels are dropped; a valid request always beats an advance.
  assign w_req_ok    = i_req && ({1'b0, i_ch} < CH_LIM);
  assign w_adv_ok    = i_adv && ({1'b0, i_adv_ch} < CH_LIM);
  assign w_req_tag   = i_addr[ADDR_W-1:OFF_W];
  assign w_req_off   = i_addr[OFF_W-1:0];
  assign w_hit       = w_req_ok && r_valid[i_ch] && (r_tag[i_ch] == w_req_tag);
  assign w_adv_tag   = r_tag[i_adv_ch] + TAG_W'(1);
  assign w_fill_ch   = w_req_ok ? i_ch : i_adv_ch;
  assign w_fill_tag  = w_req_ok ? w_req_tag : w_adv_tag;
  assign w_fill_addr = MEM_BASE + {w_fill_tag, {OFF_W{1'b0}}};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_ch         <= '0;
      r_off        <= '0;
      r_beat       <= '0;
      r_new_tag    <= '0;
      r_replay     <= 1'b0;
      r_flush_pend <= 1'b0;
      r_rvalid     <= 1'b0;
      r_rdata      <= '0;
      r_lock       <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      for (int c = 0; c < NUM_CH; c++) r_tag[c] <= '0;
    end else begin
      r_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_rvalid <= 1'b1;
            r_rdata  <= r_mem[i_ch][w_req_off];
          end else if (w_req_ok || w_adv_ok) begin
            r_ch               <= w_fill_ch;
            r_off              <= w_req_off;
            r_new_tag          <= w_fill_tag;
            r_replay           <= w_req_ok;
            r_valid[w_fill_ch] <= 1'b0;
            r_lock             <= 1'b1;
            r_mem_req          <= 1'b1;
            r_mem_addr         <= w_fill_addr;
            r_state            <= S_REQ;
          end
          // A flush seen during the previous fill lands here, one edge after completion.
          if (i_flush || r_flush_pend) begin
            r_valid      <= '0;
            r_flush_pend <= 1'b0;
          end
        end
        S_REQ: begin
          if (i_flush) r_flush_pend <= 1'b1;
          if (i_mem_gnt) begin
            r_mem_req <= 1'b0;
            r_beat    <= '0;
            r_state   <= S_FILL;
          end
        end
        S_FILL: begin
          if (i_flush) r_flush_pend <= 1'b1;
          if (i_mem_rvalid) begin
            r_beat <= r_beat + OFF_W'(1);
            if (r_replay && (r_beat == r_off)) r_rdata <= i_mem_rdata;
            if (r_beat == LAST_BEAT) begin
              r_valid[r_ch] <= 1'b1;
              r_tag[r_ch]   <= r_new_tag;
              r_lock        <= 1'b0;
              r_rvalid      <= r_replay;
              r_state       <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == S_FILL) && i_mem_rvalid) r_mem[r_ch][r_beat] <= i_mem_rdata;
  end

  assign o_rvalid    = r_rvalid;
  assign o_rdata     = r_rdata;
  assign o_lock_core = r_lock;
  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_mem_addr;
  assign o_valid_map = r_valid;

endmodule

// File: tb/tb_mcu_window_cache.sv
// Directed plus randomized bench for mcu_window_cache against a window-level reference model.
module tb_mcu_window_cache;

  localparam logic [31:0] MEM_BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        i_req;
  logic [0:0]  i_ch;
  logic [31:0] i_addr;
  logic        o_rvalid;
  logic [15:0] o_rdata;
  logic        o_lock_core;
  logic        i_adv;
  logic [0:0]  i_adv_ch;
  logic        i_flush;
  logic [1:0]  o_valid_map;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [15:0] i_mem_rdata;

  int total = 0;
  int bad = 0;

  logic [28:0] mTag [2];
  bit          mValid [2];
  logic [15:0] mData [2][8];

  mcu_window_cache #(.ADDR_W(32), .DATA_W(16), .DEPTH(8), .NUM_CH(2), .MEM_BASE(MEM_BASE)) dut (
    .clk(clk), .n_rst(n_rst),
    .i_req(i_req), .i_ch(i_ch), .i_addr(i_addr),
    .o_rvalid(o_rvalid), .o_rdata(o_rdata), .o_lock_core(o_lock_core),
    .i_adv(i_adv), .i_adv_ch(i_adv_ch), .i_flush(i_flush),
    .o_valid_map(o_valid_map),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_gnt(i_mem_gnt),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] mapOf();
    return {30'b0, 1'(mValid[1]), 1'(mValid[0])};
  endfunction

  function automatic logic [31:0] windowAddr(input logic [28:0] t);
    return MEM_BASE + {t, 3'b000};
  endfunction

  // Entered one cycle after the causing request/advance; memory grants immediately and streams 8 beats.
  task automatic serviceFill(input int ch, input logic [28:0] newTag, input bit replay,
                             input int off, input int flushBeat);
    logic [31:0] ma;
    ma = windowAddr(newTag);
    checkOutput("miss_lock", 32'(o_lock_core), 1);
    checkOutput("miss_mem_req", 32'(o_mem_req), 1);
    checkOutput("miss_mem_addr", o_mem_addr, ma);
    checkOutput("miss_map", 32'(o_valid_map), mapOf());
    i_mem_gnt = 1'b1;
    stepCycle();
    i_mem_gnt = 1'b0;
    checkOutput("gnt_mem_req_drop", 32'(o_mem_req), 0);
    for (int b = 0; b < 8; b++) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = ma[15:0] + 16'(b);
      i_flush      = (b == flushBeat);
      mData[ch][b] = ma[15:0] + 16'(b);
      stepCycle();
      i_mem_rvalid = 1'b0;
      i_flush      = 1'b0;
      if (b == 3) checkOutput("fill_lock_held", 32'(o_lock_core), 1);
    end
    mValid[ch] = 1'b1;
    mTag[ch]   = newTag;
    checkOutput("fill_rvalid", 32'(o_rvalid), 32'(replay));
    if (replay) checkOutput("fill_rdata", 32'(o_rdata), 32'(mData[ch][off]));
    checkOutput("fill_unlock", 32'(o_lock_core), 0);
    checkOutput("fill_map", 32'(o_valid_map), mapOf());
    if (flushBeat >= 0) begin
      mValid[0] = 1'b0;
      mValid[1] = 1'b0;
      stepCycle();
      checkOutput("late_flush_map", 32'(o_valid_map), 0);
      checkOutput("late_flush_rvalid", 32'(o_rvalid), 0);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic [31:0] addr, input bit advAlso, input int flushBeat);
    logic [28:0] t;
    int off;
    t   = addr[31:3];
    off = int'(addr[2:0]);
    i_req    = 1'b1;
    i_ch     = 1'(ch);
    i_addr   = addr;
    i_adv    = advAlso;
    i_adv_ch = 1'(1 - ch);
    stepCycle();
    i_req = 1'b0;
    i_adv = 1'b0;
    if (mValid[ch] && (mTag[ch] == t)) begin
      checkOutput("hit_rvalid", 32'(o_rvalid), 1);
      checkOutput("hit_rdata", 32'(o_rdata), 32'(mData[ch][off]));
      checkOutput("hit_no_mem_req", 32'(o_mem_req), 0);
      checkOutput("hit_no_lock", 32'(o_lock_core), 0);
      if (advAlso) begin
        stepCycle();
        checkOutput("adv_dropped_mem_req", 32'(o_mem_req), 0);
        checkOutput("adv_dropped_lock", 32'(o_lock_core), 0);
        checkOutput("adv_dropped_map", 32'(o_valid_map), mapOf());
      end
    end else begin
      mValid[ch] = 1'b0;
      serviceFill(ch, t, 1'b1, off, flushBeat);
    end
  endtask

  task automatic doAdvance(input int ch);
    i_adv    = 1'b1;
    i_adv_ch = 1'(ch);
    stepCycle();
    i_adv = 1'b0;
    mValid[ch] = 1'b0;
    serviceFill(ch, mTag[ch] + 29'd1, 1'b0, 0, -1);
  endtask

  task automatic doFlush();
    i_flush = 1'b1;
    stepCycle();
    i_flush = 1'b0;
    mValid[0] = 1'b0;
    mValid[1] = 1'b0;
    checkOutput("idle_flush_map", 32'(o_valid_map), 0);
  endtask

  initial begin
    logic [31:0] pool [5];
    n_rst = 1'b0; i_req = 1'b0; i_ch = '0; i_addr = '0; i_adv = 1'b0; i_adv_ch = '0;
    i_flush = 1'b0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    for (int c = 0; c < 2; c++) begin mValid[c] = 1'b0; mTag[c] = '0; end
    pool[0] = 32'h10; pool[1] = 32'h18; pool[2] = 32'h40; pool[3] = 32'h1000; pool[4] = 32'hFFFF_FFF8;

    repeat (2) stepCycle();
    checkOutput("rst_rvalid", 32'(o_rvalid), 0);
    checkOutput("rst_rdata", 32'(o_rdata), 0);
    checkOutput("rst_lock", 32'(o_lock_core), 0);
    checkOutput("rst_mem_req", 32'(o_mem_req), 0);
    checkOutput("rst_mem_addr", o_mem_addr, 0);
    checkOutput("rst_map", 32'(o_valid_map), 0);
    n_rst = 1'b1;
    stepCycle();

    applyStimulus(0, 32'h13, 1'b0, -1);
    applyStimulus(0, 32'h17, 1'b0, -1);
    stepCycle();
    checkOutput("rvalid_one_cycle", 32'(o_rvalid), 0);
    applyStimulus(1, 32'h13, 1'b0, -1);
    checkOutput("both_valid_map", 32'(o_valid_map), 32'h3);

    doAdvance(0);
    applyStimulus(0, 32'h1A, 1'b0, -1);
    applyStimulus(0, 32'h1C, 1'b1, -1);

    applyStimulus(1, 32'hFFFF_FFF8, 1'b0, -1);
    doAdvance(1);
    checkOutput("wrap_tag_model", 32'(mTag[1]), 0);

    applyStimulus(0, 32'h44, 1'b0, 5);
    for (int b = 0; b < 3; b++) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 16'hDEAD;
      stepCycle();
    end
    i_mem_rvalid = 1'b0;
    checkOutput("idle_beats_map", 32'(o_valid_map), 0);
    checkOutput("idle_beats_rvalid", 32'(o_rvalid), 0);
    applyStimulus(0, 32'h44, 1'b0, -1);
    for (int b = 0; b < 3; b++) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 16'hBEEF;
      stepCycle();
    end
    i_mem_rvalid = 1'b0;
    applyStimulus(0, 32'h45, 1'b0, -1);

    // Reset in the middle of a burst.
    i_req = 1'b1; i_ch = 1'b1; i_addr = 32'h30;
    stepCycle();
    i_req = 1'b0;
    checkOutput("abort_lock", 32'(o_lock_core), 1);
    i_mem_gnt = 1'b1;
    stepCycle();
    i_mem_gnt = 1'b0;
    for (int b = 0; b < 3; b++) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 16'h0030 + 16'(b);
      stepCycle();
    end
    n_rst = 1'b0;
    #1;
    checkOutput("abort_rvalid", 32'(o_rvalid), 0);
    checkOutput("abort_rdata", 32'(o_rdata), 0);
    checkOutput("abort_lock_clr", 32'(o_lock_core), 0);
    checkOutput("abort_mem_req", 32'(o_mem_req), 0);
    checkOutput("abort_mem_addr", o_mem_addr, 0);
    checkOutput("abort_map", 32'(o_valid_map), 0);
    for (int b = 3; b < 5; b++) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 16'h0030 + 16'(b);
      stepCycle();
    end
    n_rst = 1'b1;
    for (int b = 5; b < 8; b++) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 16'h0030 + 16'(b);
      stepCycle();
    end
    i_mem_rvalid = 1'b0;
    mValid[0] = 1'b0;
    mValid[1] = 1'b0;
    checkOutput("post_abort_rvalid", 32'(o_rvalid), 0);
    checkOutput("post_abort_lock", 32'(o_lock_core), 0);
    checkOutput("post_abort_map", 32'(o_valid_map), 0);
    applyStimulus(1, 32'h33, 1'b0, -1);

    for (int n = 0; n < 40; n++) begin
      int ch, r, fb;
      logic [31:0] a;
      ch = int'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 9));
      a  = pool[$urandom_range(0, 4)] + 32'($urandom_range(0, 7));
      fb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1;
      if (r == 0) doFlush();
      else if (r == 1 && mValid[ch]) doAdvance(ch);
      else applyStimulus(ch, a, 1'b0, fb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
